// File: rtl/game_pkg.sv
// Shared types for the game score controller: FSM states, winner encoding, event flags.
package game_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } game_state_t;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_t;

  // Registered per-cycle event flags driven toward the counter side.
  typedef struct packed {
    logic winner;
    logic loser;
    logic gameover;
  } game_flags_t;

  // Tally width able to hold 0..target.
  function automatic int unsigned tally_width(input int unsigned target);
    return $clog2(target + 1);
  endfunction

endpackage

// File: rtl/game_score_ctrl_if.sv
// Counter-to-score-controller link: counter drives count, controller returns game status.
interface game_score_ctrl_if
  import game_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TALLY_W = 4
);

  logic [WIDTH-1:0]   count;
  logic               WINNER;
  logic               LOSER;
  logic               GAMEOVER;
  who_t               WHO;
  logic [TALLY_W-1:0] win_tally;
  logic [TALLY_W-1:0] lose_tally;

  modport master (
    output count,
    input  WINNER, LOSER, GAMEOVER, WHO, win_tally, lose_tally
  );

  modport slave (
    input  count,
    output WINNER, LOSER, GAMEOVER, WHO, win_tally, lose_tally
  );

endinterface

// File: rtl/game_tally_cnt.sv
// Event tally for one side; flags the increment that would reach TARGET.
module game_tally_cnt #(
  parameter int unsigned TARGET  = 15,
  parameter int unsigned TALLY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [TALLY_W-1:0] tally,
  output logic               hit_target
);

  localparam logic [TALLY_W-1:0] LAST = TALLY_W'(TARGET - 1);

  assign hit_target = inc && (tally == LAST);

  // Clear wins over increment so the game-ending event never shows TARGET.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tally <= '0;
    end else if (inc) begin
      tally <= tally + TALLY_W'(1);
    end
  end

endmodule

// File: rtl/game_score_ctrl.sv
// Watches the counter value, flags extremes, tallies them and ends the game at TARGET events.
module game_score_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned TARGET         = 15,
  parameter bit          PULSE_ON_ENTRY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  game_score_ctrl_if.slave  bus
);

  localparam int unsigned TALLY_W = tally_width(TARGET);

  game_state_t        state, state_nxt;
  who_t               who, who_nxt;
  game_flags_t        flags, flags_nxt;
  logic               prev_max, prev_min;
  logic               is_max, is_min;
  logic               hit_max, hit_min;
  logic               win_evt, lose_evt;
  logic               win_hit, lose_hit;
  logic               clr;
  logic [TALLY_W-1:0] win_tally, lose_tally;

  assign is_max  = &bus.count;
  assign is_min  = ~|bus.count;
  assign hit_max = is_max && (!PULSE_ON_ENTRY || !prev_max);
  assign hit_min = is_min && (!PULSE_ON_ENTRY || !prev_min);

  // Samples only count while playing; the OVER cycle ignores them.
  assign win_evt  = (state == PLAY) && hit_max;
  assign lose_evt = (state == PLAY) && hit_min;

  game_tally_cnt #(
    .TARGET  (TARGET),
    .TALLY_W (TALLY_W)
  ) u_win_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (win_evt),
    .clr        (clr),
    .tally      (win_tally),
    .hit_target (win_hit)
  );

  game_tally_cnt #(
    .TARGET  (TARGET),
    .TALLY_W (TALLY_W)
  ) u_lose_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (lose_evt),
    .clr        (clr),
    .tally      (lose_tally),
    .hit_target (lose_hit)
  );

  // State, status outputs and entry-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PLAY;
      who      <= WHO_NONE;
      flags    <= '0;
      prev_max <= 1'b0;
      prev_min <= 1'b0;
    end else begin
      state    <= state_nxt;
      who      <= who_nxt;
      flags    <= flags_nxt;
      prev_max <= is_max;
      prev_min <= is_min;
    end
  end

  // Next state and next status; a tally reaching TARGET ends the game.
  always_comb begin
    state_nxt = state;
    who_nxt   = who;
    flags_nxt = '0;
    clr       = 1'b0;
    unique case (state)
      PLAY: begin
        flags_nxt.winner = win_evt;
        flags_nxt.loser  = lose_evt;
        if (win_hit || lose_hit) begin
          clr                = 1'b1;
          flags_nxt.gameover = 1'b1;
          who_nxt            = win_hit ? WHO_WINNER : WHO_LOSER;
          state_nxt          = OVER;
        end
      end
      OVER: begin
        state_nxt = PLAY;
      end
    endcase
  end

  assign bus.WINNER     = flags.winner;
  assign bus.LOSER      = flags.loser;
  assign bus.GAMEOVER   = flags.gameover;
  assign bus.WHO        = who;
  assign bus.win_tally  = win_tally;
  assign bus.lose_tally = lose_tally;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl: three parameterisations checked against a behavioural game model.
module tb_game_score_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt = 4'd15;
  bit         armed = 1'b0;
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  game_score_ctrl_if #(.WIDTH(4), .TALLY_W(4)) if0 ();
  game_score_ctrl_if #(.WIDTH(4), .TALLY_W(4)) if1 ();
  game_score_ctrl_if #(.WIDTH(4), .TALLY_W(1)) if2 ();

  game_score_ctrl #(.WIDTH(4), .TARGET(15), .PULSE_ON_ENTRY(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  game_score_ctrl #(.WIDTH(4), .TARGET(15), .PULSE_ON_ENTRY(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  game_score_ctrl #(.WIDTH(4), .TARGET(1),  .PULSE_ON_ENTRY(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Game model: what each instance must show after every edge.
  int m_win[3], m_lose[3], m_go[3], m_who[3], m_wt[3], m_lt[3];
  bit m_over[3], m_pmax[3], m_pmin[3];

  function automatic int tgt(input int i);
    return (i == 2) ? 1 : 15;
  endfunction

  function automatic bit poe(input int i);
    return (i == 1);
  endfunction

  task automatic mstep(input int i);
    bit mx, mn, hx, hn;
    if (rst) begin
      m_win[i] = 0; m_lose[i] = 0; m_go[i] = 0; m_who[i] = 0;
      m_wt[i] = 0; m_lt[i] = 0; m_over[i] = 0; m_pmax[i] = 0; m_pmin[i] = 0;
    end else begin
      mx = (cnt == 4'd15);
      mn = (cnt == 4'd0);
      hx = mx && (!poe(i) || !m_pmax[i]);
      hn = mn && (!poe(i) || !m_pmin[i]);
      m_pmax[i] = mx;
      m_pmin[i] = mn;
      m_go[i] = 0;
      if (m_over[i]) begin
        m_win[i] = 0; m_lose[i] = 0; m_over[i] = 0;
      end else begin
        m_win[i] = hx;
        m_lose[i] = hn;
        if (hx) m_wt[i]++;
        if (hn) m_lt[i]++;
        if (m_wt[i] == tgt(i) || m_lt[i] == tgt(i)) begin
          m_who[i] = (m_wt[i] == tgt(i)) ? 2 : 1;
          m_go[i] = 1; m_wt[i] = 0; m_lt[i] = 0; m_over[i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) mstep(i);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp(input int i, input int w, input int l, input int g, input int who,
                     input int wt, input int lt);
    chk($sformatf("i%0d WINNER", i), w, m_win[i]);
    chk($sformatf("i%0d LOSER", i), l, m_lose[i]);
    chk($sformatf("i%0d GAMEOVER", i), g, m_go[i]);
    chk($sformatf("i%0d WHO", i), who, m_who[i]);
    chk($sformatf("i%0d win_tally", i), wt, m_wt[i]);
    chk($sformatf("i%0d lose_tally", i), lt, m_lt[i]);
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      cmp(0, int'(if0.WINNER), int'(if0.LOSER), int'(if0.GAMEOVER), int'(if0.WHO),
          int'(if0.win_tally), int'(if0.lose_tally));
      cmp(1, int'(if1.WINNER), int'(if1.LOSER), int'(if1.GAMEOVER), int'(if1.WHO),
          int'(if1.win_tally), int'(if1.lose_tally));
      cmp(2, int'(if2.WINNER), int'(if2.LOSER), int'(if2.GAMEOVER), int'(if2.WHO),
          int'(if2.win_tally), int'(if2.lose_tally));
    end
  end

  task automatic cyc(input logic [3:0] v, input logic r);
    cnt = v;
    rst = r;
    if0.count = v;
    if1.count = v;
    if2.count = v;
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  logic [3:0] tail [12] = '{4'd0, 4'd0, 4'd15, 4'd7, 4'd15, 4'd15, 4'd0, 4'd3, 4'd0, 4'd15, 4'd1, 4'd15};

  initial begin
    // Reset held with count at MAX
    cyc(4'd15, 1'b1);
    cyc(4'd15, 1'b1);
    chk("rst WINNER", int'(if0.WINNER), 0);
    chk("rst GAMEOVER", int'(if0.GAMEOVER), 0);
    chk("rst WHO", int'(if0.WHO), 0);
    chk("rst win_tally", int'(if0.win_tally), 0);
    chk("rst lose_tally", int'(if0.lose_tally), 0);

    // Release: first MAX sample lands next cycle; TARGET=1 ends at once
    cyc(4'd15, 1'b0);
    chk("rel WINNER", int'(if0.WINNER), 1);
    chk("rel win_tally", int'(if0.win_tally), 1);
    chk("poe WINNER 1", int'(if1.WINNER), 1);
    chk("t1 GAMEOVER", int'(if2.GAMEOVER), 1);
    chk("t1 WHO", int'(if2.WHO), 2);
    chk("t1 WINNER", int'(if2.WINNER), 1);
    cyc(4'd15, 1'b0);
    chk("hold win_tally 2", int'(if0.win_tally), 2);
    chk("poe WINNER held", int'(if1.WINNER), 0);
    chk("t1 OVER WINNER", int'(if2.WINNER), 0);
    chk("t1 OVER GAMEOVER", int'(if2.GAMEOVER), 0);
    cyc(4'd15, 1'b0);
    chk("hold WINNER 3", int'(if0.WINNER), 1);
    chk("hold win_tally 3", int'(if0.win_tally), 3);
    cyc(4'd14, 1'b0);
    chk("off WINNER", int'(if0.WINNER), 0);
    cyc(4'd15, 1'b0);
    chk("poe re-entry WINNER", int'(if1.WINNER), 1);
    chk("poe win_tally", int'(if1.win_tally), 2);
    chk("alt win_tally 4", int'(if0.win_tally), 4);

    // Alternate 15/14 up to the 15th win
    for (int k = 5; k <= 14; k++) begin
      cyc(4'd14, 1'b0);
      cyc(4'd15, 1'b0);
      chk("alt win_tally", int'(if0.win_tally), k);
    end
    cyc(4'd14, 1'b0);
    cyc(4'd15, 1'b0);
    chk("end WINNER", int'(if0.WINNER), 1);
    chk("end GAMEOVER", int'(if0.GAMEOVER), 1);
    chk("end WHO", int'(if0.WHO), 2);
    chk("end win_tally", int'(if0.win_tally), 0);
    chk("end lose_tally", int'(if0.lose_tally), 0);
    cyc(4'd15, 1'b0);
    chk("over GAMEOVER", int'(if0.GAMEOVER), 0);
    chk("over WINNER", int'(if0.WINNER), 0);
    chk("over WHO held", int'(if0.WHO), 2);
    cyc(4'd15, 1'b0);
    chk("replay WINNER", int'(if0.WINNER), 1);
    chk("replay win_tally", int'(if0.win_tally), 1);

    // 14 wins then 15 losses
    cyc(4'd15, 1'b1);
    for (int k = 0; k < 14; k++) cyc(4'd15, 1'b0);
    chk("pre win_tally 14", int'(if0.win_tally), 14);
    for (int k = 1; k <= 14; k++) begin
      cyc(4'd0, 1'b0);
      chk("loss lose_tally", int'(if0.lose_tally), k);
      cyc(4'd1, 1'b0);
    end
    cyc(4'd0, 1'b0);
    chk("lend LOSER", int'(if0.LOSER), 1);
    chk("lend GAMEOVER", int'(if0.GAMEOVER), 1);
    chk("lend WHO", int'(if0.WHO), 1);
    chk("lend win_tally", int'(if0.win_tally), 0);
    chk("lend lose_tally", int'(if0.lose_tally), 0);
    cyc(4'd1, 1'b0);
    chk("lover GAMEOVER", int'(if0.GAMEOVER), 0);
    cyc(4'd15, 1'b0);
    chk("lafter WHO", int'(if0.WHO), 1);
    chk("lafter win_tally", int'(if0.win_tally), 1);

    // Mid-game reset at 9/4
    for (int k = 0; k < 8; k++) cyc(4'd15, 1'b0);
    for (int k = 0; k < 4; k++) cyc(4'd0, 1'b0);
    chk("mid win_tally 9", int'(if0.win_tally), 9);
    chk("mid lose_tally 4", int'(if0.lose_tally), 4);
    cyc(4'd15, 1'b1);
    chk("mrst win_tally", int'(if0.win_tally), 0);
    chk("mrst lose_tally", int'(if0.lose_tally), 0);
    chk("mrst WHO", int'(if0.WHO), 0);
    chk("mrst GAMEOVER", int'(if0.GAMEOVER), 0);
    cyc(4'd15, 1'b0);
    chk("resume WINNER", int'(if0.WINNER), 1);
    chk("resume win_tally", int'(if0.win_tally), 1);

    // Mixed tail exercising entry detection on both extremes
    foreach (tail[k]) cyc(tail[k], 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
